fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, default 32, bits per instruction.
REQ-002 Parameter SUPER_SCALAR_WIDTH (SSW), default 4, maximum instructions enqueued or dequeued per cycle.
REQ-003 Parameter CACHE_LINE_WIDTH, default 64, bytes per line.
REQ-004 Parameter QUEUE_DEPTH, default 16, instruction entries; power of two, >= 2*SSW.
REQ-005 clk_in  in  1  single clock, all state on its rising edge.
REQ-006 rst_in  in  1  reset, asynchronous, active-high.
REQ-007 flush_in  in  1  misprediction flush.
REQ-008 pc_valid_in  in  1 / pc_in  in  64  fetch request from the branch predictor.
REQ-009 l0_valid_in  in  1 / l0_cacheline_in  in  8 x CACHE_LINE_WIDTH  same-cycle L0 hit line for pc_in.
REQ-010 l1i_req_valid_out  out  1 / l1i_req_addr_out  out  64 / l1i_req_ready_in  in  1  L1i miss request handshake.
REQ-011 l1i_valid_in  in  1 / l1i_cacheline_in  in  8 x CACHE_LINE_WIDTH  L1i response.
REQ-012 fetch_ready_out  out  1  request accepted this cycle if pc_valid_in is high.
REQ-013 decode_ready_in  in  1  decode consumes the presented group.
REQ-014 instrs_out  out  INSTRUCTION_WIDTH x SSW / instr_valid_out  out  SSW / instr_pc_out  out  64  oldest entries, slot-0 PC.

Function
REQ-015 States: IDLE, REQ, WAIT, DISCARD.
REQ-016 fetch_ready_out = (state==IDLE) & (free entries >= SSW, from the registered count) & ~flush_in.
REQ-017 Accept = pc_valid_in & fetch_ready_out; pc_in[1:0] is ignored (treated as 0).
REQ-018 Accept with l0_valid_in: enqueue n = min(SSW, (CACHE_LINE_WIDTH - offset)/4) instructions, visible one cycle later; state stays IDLE.
REQ-019 Instruction i = little-endian bytes offset+4i..offset+4i+3 of the line; no padding is inserted past the line end.
REQ-020 Each entry stores its PC; consecutive entries from one line differ by 4.
REQ-021 Accept without l0_valid_in: latch pc_in; enter REQ; l1i_req_addr_out = pc with the low log2(CACHE_LINE_WIDTH) bits cleared.
REQ-022 REQ: l1i_req_valid_out is high and stable until l1i_req_ready_in; on the handshake, enter WAIT.
REQ-023 WAIT: on l1i_valid_in, enqueue per REQ-018/019 from the latched PC offset; return to IDLE.
REQ-024 Dequeue: present up to SSW oldest entries; instr_valid_out is contiguous from slot 0, popcount = min(count, SSW); unused slots are zero.
REQ-025 decode_ready_in high pops all presented valid entries that cycle; simultaneous enqueue and pop is allowed; count' = count + n - popped.
REQ-026 Read and write pointers wrap modulo QUEUE_DEPTH; overflow is impossible by REQ-016.
REQ-027 flush_in: the queue is emptied next cycle and the same-cycle pop and enqueue are suppressed.
- REQ -> IDLE, request dropped.
- WAIT -> DISCARD; if l1i_valid_in is high the same cycle, go to IDLE with the response dropped.
- IDLE and DISCARD hold their state.
REQ-028 DISCARD: l1i_valid_in is dropped, not enqueued; enter IDLE.
REQ-029 Only one L1i miss is outstanding at a time; l1i_valid_in in IDLE or REQ is ignored.

Reset
REQ-030 rst_in high asynchronously forces:
- state IDLE; pointers and count 0;
- all outputs 0, including fetch_ready_out and l1i_req_valid_out.
REQ-031 First accept is possible in the first cycle after rst_in deasserts; reset mid-miss abandons the miss with no discard tracking.

Verification (SSW=4, line 64, depth 16)
REQ-032 pc 0x1000, L0 hit -> next cycle instr_valid_out=1111, instr_pc_out=0x1000, instrs = line bytes 0-15.
REQ-033 pc 0x1038, L0 hit -> exactly 2 entries, instr_valid_out=0011, PCs 0x1038/0x103C.
REQ-034 pc 0x2010, no L0 hit, l1i_req_ready_in low 3 cycles -> l1i_req_valid_out held with addr 0x2000; after the response, 4 entries from offset 16, PC 0x2010.
REQ-035 flush in WAIT, response 2 cycles later -> DISCARD, nothing enqueued, fetch_ready_out high the cycle after the response.
REQ-036 decode_ready_in low, 4 L0 hits -> count 16, fetch_ready_out low from count 13; then pop 4/cycle while enqueuing across the pointer wrap -> order and PCs intact.
REQ-037 rst_in raised mid-WAIT -> all outputs 0 with no clock edge; a later stray l1i_valid_in enqueues nothing.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: takes predicted PCs, fills from an L0 hit or a single outstanding
// L1i miss, and presents up to SUPER_SCALAR_WIDTH of the oldest instructions to decode.
module fetch_buffer #(
    parameter int unsigned INSTRUCTION_WIDTH  = 32,
    parameter int unsigned SUPER_SCALAR_WIDTH = 4,
    parameter int unsigned CACHE_LINE_WIDTH   = 64,
    parameter int unsigned QUEUE_DEPTH        = 16
) (
    input  logic                                            clk_in,
    input  logic                                            rst_in,
    input  logic                                            flush_in,
    input  logic                                            pc_valid_in,
    input  logic [63:0]                                     pc_in,
    input  logic                                            l0_valid_in,
    input  logic [8*CACHE_LINE_WIDTH-1:0]                   l0_cacheline_in,
    output logic                                            l1i_req_valid_out,
    output logic [63:0]                                     l1i_req_addr_out,
    input  logic                                            l1i_req_ready_in,
    input  logic                                            l1i_valid_in,
    input  logic [8*CACHE_LINE_WIDTH-1:0]                   l1i_cacheline_in,
    output logic                                            fetch_ready_out,
    input  logic                                            decode_ready_in,
    output logic [INSTRUCTION_WIDTH*SUPER_SCALAR_WIDTH-1:0] instrs_out,
    output logic [SUPER_SCALAR_WIDTH-1:0]                   instr_valid_out,
    output logic [63:0]                                     instr_pc_out
);

    localparam int unsigned SSW       = SUPER_SCALAR_WIDTH;
    localparam int unsigned IW        = INSTRUCTION_WIDTH;
    localparam int unsigned LINE_BITS = 8 * CACHE_LINE_WIDTH;
    localparam int unsigned IDX_W     = $clog2(LINE_BITS);
    localparam int unsigned OUT_W     = IW * SSW;
    localparam int unsigned OUT_IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned SLOT_W    = (SSW > 1) ? $clog2(SSW) : 1;
    localparam int unsigned OFF_W     = $clog2(CACHE_LINE_WIDTH);
    localparam int unsigned PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [63:0]         r_miss_pc;
    logic [IW-1:0]       r_instr [QUEUE_DEPTH];
    logic [63:0]         r_pc    [QUEUE_DEPTH];
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W-1:0]    r_wptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_fetch_ready;
    logic                w_accept;
    logic                w_enq;
    logic                w_latch;
    logic [63:0]         w_pc_aligned;
    logic [63:0]         w_enq_pc;
    logic [LINE_BITS-1:0] w_enq_line;
    logic [CNT_W-1:0]    w_free;
    logic [CNT_W-1:0]    w_avail;
    logic [CNT_W-1:0]    w_enq_n;
    logic [CNT_W-1:0]    w_pop_n;
    logic [SSW-1:0][IW-1:0] w_enq_data;

    assign w_pc_aligned  = pc_in & ~64'h3;
    assign w_free        = CNT_W'(QUEUE_DEPTH) - r_count;
    assign w_fetch_ready = (r_state == ST_IDLE) && (w_free >= CNT_W'(SSW)) && !flush_in && !rst_in;
    assign w_accept      = pc_valid_in && w_fetch_ready;
    assign w_avail       = (r_count < CNT_W'(SSW)) ? r_count : CNT_W'(SSW);
    assign w_pop_n       = (decode_ready_in && !flush_in) ? w_avail : '0;

    assign fetch_ready_out   = w_fetch_ready;
    assign l1i_req_valid_out = (r_state == ST_REQ);
    assign l1i_req_addr_out  = {r_miss_pc[63:OFF_W], {OFF_W{1'b0}}};

    // Miss state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and selection of the line/PC feeding the queue
    always_comb begin
        w_state_next = r_state;
        w_enq        = 1'b0;
        w_latch      = 1'b0;
        w_enq_pc     = w_pc_aligned;
        w_enq_line   = l0_cacheline_in;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (l0_valid_in) begin
                        w_enq = 1'b1;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (flush_in) begin
                    w_state_next = ST_IDLE;
                end else if (l1i_req_ready_in) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_in) begin
                    w_state_next = l1i_valid_in ? ST_IDLE : ST_DISCARD;
                end else if (l1i_valid_in) begin
                    w_enq        = 1'b1;
                    w_enq_pc     = r_miss_pc;
                    w_enq_line   = l1i_cacheline_in;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (!flush_in && l1i_valid_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Slice the enqueue line into instructions; stops at the line end, no padding
    always_comb begin
        int unsigned off;
        int unsigned words_left;
        int unsigned n;
        off        = 32'(w_enq_pc[OFF_W-1:0]);
        words_left = (CACHE_LINE_WIDTH - off) / 4;
        n          = (words_left < SSW) ? words_left : SSW;
        w_enq_n    = w_enq ? CNT_W'(n) : '0;
        w_enq_data = '0;
        for (int unsigned i = 0; i < SSW; i++) begin
            if (i < n) begin
                w_enq_data[SLOT_W'(i)] = w_enq_line[IDX_W'((off + 4 * i) * 8) +: IW];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_miss_pc <= '0;
        end else if (w_latch) begin
            r_miss_pc <= w_pc_aligned;
        end
    end

    // Queue bookkeeping; flush empties the queue and drops this cycle's pop/enqueue
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (flush_in) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            r_rptr  <= r_rptr + w_pop_n[PTR_W-1:0];
            r_wptr  <= r_wptr + w_enq_n[PTR_W-1:0];
            r_count <= r_count + w_enq_n - w_pop_n;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < SSW; i++) begin
            if (CNT_W'(i) < w_enq_n) begin
                r_instr[r_wptr + PTR_W'(i)] <= w_enq_data[SLOT_W'(i)];
                r_pc[r_wptr + PTR_W'(i)]    <= w_enq_pc + 64'(4 * i);
            end
        end
    end

    // Present the oldest entries; unused slots read as zero
    always_comb begin
        instrs_out      = '0;
        instr_valid_out = '0;
        instr_pc_out    = '0;
        for (int unsigned s = 0; s < SSW; s++) begin
            if (CNT_W'(s) < r_count) begin
                instr_valid_out[SLOT_W'(s)]           = 1'b1;
                instrs_out[OUT_IDX_W'(s * IW) +: IW] = r_instr[r_rptr + PTR_W'(s)];
            end
        end
        if (r_count != '0) begin
            instr_pc_out = r_pc[r_rptr];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_buffer;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         flush_in;
    logic         pc_valid_in;
    logic [63:0]  pc_in;
    logic         l0_valid_in;
    logic [511:0] l0_cacheline_in;
    logic         l1i_req_valid_out;
    logic [63:0]  l1i_req_addr_out;
    logic         l1i_req_ready_in;
    logic         l1i_valid_in;
    logic [511:0] l1i_cacheline_in;
    logic         fetch_ready_out;
    logic         decode_ready_in;
    logic [127:0] instrs_out;
    logic [3:0]   instr_valid_out;
    logic [63:0]  instr_pc_out;

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;
    int unsigned n_failed = 0;

    // Reference model: instruction/PC queue plus the single outstanding miss
    logic [31:0] mq_i[$];
    logic [63:0] mq_p[$];
    bit          m_req;
    bit          m_wait;
    bit          m_discard;
    logic [63:0] m_miss_pc;

    fetch_buffer dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .flush_in          (flush_in),
        .pc_valid_in       (pc_valid_in),
        .pc_in             (pc_in),
        .l0_valid_in       (l0_valid_in),
        .l0_cacheline_in   (l0_cacheline_in),
        .l1i_req_valid_out (l1i_req_valid_out),
        .l1i_req_addr_out  (l1i_req_addr_out),
        .l1i_req_ready_in  (l1i_req_ready_in),
        .l1i_valid_in      (l1i_valid_in),
        .l1i_cacheline_in  (l1i_cacheline_in),
        .fetch_ready_out   (fetch_ready_out),
        .decode_ready_in   (decode_ready_in),
        .instrs_out        (instrs_out),
        .instr_valid_out   (instr_valid_out),
        .instr_pc_out      (instr_pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_line(output logic [511:0] ln);
        for (int i = 0; i < 16; i++) ln[i*32 +: 32] = $urandom;
    endtask

    task automatic idle_inputs();
        flush_in         = 1'b0;
        pc_valid_in      = 1'b0;
        pc_in            = '0;
        l0_valid_in      = 1'b0;
        l0_cacheline_in  = '0;
        l1i_req_ready_in = 1'b0;
        l1i_valid_in     = 1'b0;
        l1i_cacheline_in = '0;
        decode_ready_in  = 1'b0;
    endtask

    function automatic bit m_ready();
        return !(m_req || m_wait || m_discard) && (16 - mq_i.size() >= 4) && !flush_in && !rst_in;
    endfunction

    function automatic int m_shown();
        return (mq_i.size() < 4) ? mq_i.size() : 4;
    endfunction

    task automatic m_push(input logic [511:0] ln, input logic [63:0] pc);
        int off;
        int n;
        off = int'(pc[5:0]);
        n   = (64 - off) / 4;
        if (n > 4) n = 4;
        for (int i = 0; i < n; i++) begin
            mq_i.push_back(ln[9'((off + 4 * i) * 8) +: 32]);
            mq_p.push_back(pc + 64'(4 * i));
        end
    endtask

    task automatic m_clear();
        mq_i.delete();
        mq_p.delete();
        m_req     = 1'b0;
        m_wait    = 1'b0;
        m_discard = 1'b0;
        m_miss_pc = '0;
    endtask

    task automatic check_outputs();
        int           k;
        logic [127:0] ei;
        logic [3:0]   ev;
        k  = m_shown();
        ei = '0;
        ev = '0;
        for (int s = 0; s < k; s++) begin
            ei[7'(s * 32) +: 32] = mq_i[s];
            ev[2'(s)]            = 1'b1;
        end
        chk("fetch_ready", 128'(fetch_ready_out), 128'(m_ready()));
        chk("l1i_req_valid", 128'(l1i_req_valid_out), 128'(m_req));
        if (m_req) chk("l1i_req_addr", 128'(l1i_req_addr_out), 128'({m_miss_pc[63:6], 6'b0}));
        chk("instr_valid", 128'(instr_valid_out), 128'(ev));
        chk("instr_pc", 128'(instr_pc_out), (k > 0) ? 128'(mq_p[0]) : 128'(0));
        chk("instrs", instrs_out, ei);
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit acc;
        bit resp;
        int k;
        acc  = pc_valid_in && m_ready();
        resp = m_wait && l1i_valid_in;
        k    = m_shown();
        if (flush_in) begin
            mq_i.delete();
            mq_p.delete();
            m_req = 1'b0;
            if (m_wait) begin
                m_wait    = 1'b0;
                m_discard = !l1i_valid_in;
            end
        end else begin
            if (decode_ready_in) begin
                repeat (k) begin
                    void'(mq_i.pop_front());
                    void'(mq_p.pop_front());
                end
            end
            if (acc && l0_valid_in) m_push(l0_cacheline_in, pc_in & ~64'h3);
            if (resp) m_push(l1i_cacheline_in, m_miss_pc);
            if (acc && !l0_valid_in) begin
                m_req     = 1'b1;
                m_miss_pc = pc_in & ~64'h3;
            end else if (m_req && l1i_req_ready_in) begin
                m_req  = 1'b0;
                m_wait = 1'b1;
            end else if (resp) begin
                m_wait = 1'b0;
            end else if (m_discard && l1i_valid_in) begin
                m_discard = 1'b0;
            end
        end
    endtask

    // Called just after a falling edge with inputs applied
    task automatic do_cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        #2 rst_in = 1'b1;
        #1;
        chk("rst_fetch_ready", 128'(fetch_ready_out), 128'(0));
        chk("rst_req_valid", 128'(l1i_req_valid_out), 128'(0));
        chk("rst_req_addr", 128'(l1i_req_addr_out), 128'(0));
        chk("rst_instr_valid", 128'(instr_valid_out), 128'(0));
        chk("rst_instr_pc", 128'(instr_pc_out), 128'(0));
        chk("rst_instrs", instrs_out, 128'(0));
        m_clear();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        decode_ready_in = 1'b1;
        repeat (5) do_cycle();
        decode_ready_in = 1'b0;
    endtask

    task automatic l0_hit(input logic [63:0] pc, output logic [511:0] ln);
        rand_line(ln);
        pc_valid_in     = 1'b1;
        pc_in           = pc;
        l0_valid_in     = 1'b1;
        l0_cacheline_in = ln;
    endtask

    initial begin
        logic [511:0] line;
        idle_inputs();
        m_clear();
        rst_in = 1'b1;
        @(negedge clk_in);
        do_reset();

        // Aligned L0 hit
        l0_hit(64'h1000, line);
        do_cycle();
        idle_inputs();
        #1;
        chk("hit0_valid", 128'(instr_valid_out), 128'(4'b1111));
        chk("hit0_pc", 128'(instr_pc_out), 128'(64'h1000));
        chk("hit0_instrs", instrs_out, line[127:0]);
        drain();

        // L0 hit near line end: only two instructions fit
        l0_hit(64'h1038, line);
        do_cycle();
        idle_inputs();
        #1;
        chk("tail_valid", 128'(instr_valid_out), 128'(4'b0011));
        chk("tail_pc", 128'(instr_pc_out), 128'(64'h1038));
        chk("tail_instrs", instrs_out, {64'h0, line[511:448]});
        drain();

        // L1i miss with back-pressure on the request
        pc_valid_in = 1'b1;
        pc_in       = 64'h2012;
        do_cycle();
        idle_inputs();
        repeat (3) begin
            #1;
            chk("miss_req_valid", 128'(l1i_req_valid_out), 128'(1));
            chk("miss_req_addr", 128'(l1i_req_addr_out), 128'(64'h2000));
            do_cycle();
        end
        l1i_req_ready_in = 1'b1;
        do_cycle();
        idle_inputs();
        do_cycle();
        rand_line(line);
        l1i_valid_in     = 1'b1;
        l1i_cacheline_in = line;
        do_cycle();
        idle_inputs();
        #1;
        chk("miss_valid", 128'(instr_valid_out), 128'(4'b1111));
        chk("miss_pc", 128'(instr_pc_out), 128'(64'h2010));
        chk("miss_instrs", instrs_out, line[255:128]);
        drain();

        // Flush while waiting on L1i: the late response is discarded
        pc_valid_in = 1'b1;
        pc_in       = 64'h3004;
        do_cycle();
        idle_inputs();
        l1i_req_ready_in = 1'b1;
        do_cycle();
        idle_inputs();
        flush_in = 1'b1;
        do_cycle();
        idle_inputs();
        #1;
        chk("discard_ready", 128'(fetch_ready_out), 128'(0));
        do_cycle();
        rand_line(line);
        l1i_valid_in     = 1'b1;
        l1i_cacheline_in = line;
        #1;
        chk("discard_resp_ready", 128'(fetch_ready_out), 128'(0));
        do_cycle();
        idle_inputs();
        #1;
        chk("post_discard_ready", 128'(fetch_ready_out), 128'(1));
        chk("post_discard_valid", 128'(instr_valid_out), 128'(0));
        do_cycle();

        // Fill to 16, then stream across the pointer wrap
        for (int j = 0; j < 4; j++) begin
            l0_hit(64'h4000 + 64'(16 * j), line);
            do_cycle();
        end
        idle_inputs();
        pc_valid_in = 1'b1;
        l0_valid_in = 1'b1;
        #1;
        chk("full_ready", 128'(fetch_ready_out), 128'(0));
        for (int j = 0; j < 8; j++) begin
            l0_hit(64'h4100 + 64'(16 * j), line);
            decode_ready_in = 1'b1;
            do_cycle();
        end
        drain();

        // Count 13 already blocks a further request
        for (int j = 0; j < 3; j++) begin
            l0_hit(64'h5000 + 64'(16 * j), line);
            do_cycle();
        end
        l0_hit(64'h503C, line);
        #1;
        chk("count12_ready", 128'(fetch_ready_out), 128'(1));
        do_cycle();
        idle_inputs();
        pc_valid_in = 1'b1;
        #1;
        chk("count13_ready", 128'(fetch_ready_out), 128'(0));
        drain();

        // Reset during an outstanding miss; a stray response afterwards is ignored
        pc_valid_in = 1'b1;
        pc_in       = 64'h6000;
        do_cycle();
        idle_inputs();
        l1i_req_ready_in = 1'b1;
        do_cycle();
        idle_inputs();
        do_cycle();
        do_reset();
        rand_line(line);
        l1i_valid_in     = 1'b1;
        l1i_cacheline_in = line;
        do_cycle();
        idle_inputs();
        #1;
        chk("stray_resp_valid", 128'(instr_valid_out), 128'(0));
        do_cycle();

        // Randomized traffic
        repeat (3000) begin
            flush_in         = ($urandom_range(0, 15) == 0);
            pc_valid_in      = $urandom_range(0, 1) == 1;
            pc_in            = {32'h0, $urandom};
            l0_valid_in      = $urandom_range(0, 1) == 1;
            rand_line(line);
            l0_cacheline_in  = line;
            l1i_req_ready_in = $urandom_range(0, 1) == 1;
            l1i_valid_in     = ($urandom_range(0, 9) < 3);
            rand_line(line);
            l1i_cacheline_in = line;
            decode_ready_in  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 399) == 0) do_reset();
            else do_cycle();
        end
        drain();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
